// File: rtl/matched_filter_pulse_inject.sv
// SSR pulse injector: adds an amplitude-scaled copy of the matched-filter template
// into an 8-sample-per-clock stream, starting at any lane phase, with saturation.

module mfpi_lane #(
    parameter int NBITS = 12
) (
    input  logic                    active_i,
    input  logic signed [7:0]       n_i,
    input  logic signed [NBITS-1:0] amp_i,
    output logic signed [NBITS+2:0] contrib_o
);
    localparam logic signed [3:0] TMPL [0:41] = '{
        4'sd1, 4'sd1, -4'sd1, -4'sd2, 4'sd1, 4'sd4, 4'sd1, -4'sd4, -4'sd4, 4'sd0,
        4'sd4, 4'sd2, 4'sd0, -4'sd2, -4'sd2, -4'sd1, 4'sd0, 4'sd1,
        4'sd2, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1, 4'sd0, 4'sd1,
        4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1, 4'sd0,
        4'sd0, 4'sd1, 4'sd1, 4'sd0, 4'sd0, 4'sd0, -4'sd1, -4'sd1
    };

    logic signed [3:0]       s;
    logic signed [NBITS+2:0] a;

    // Template taps are only 0, +-1, +-2, +-4, so shifts and a negate cover every product.
    always_comb begin
        s = '0;
        if (active_i && n_i >= 8'sd0 && n_i <= 8'sd41) s = TMPL[n_i[5:0]];
        a = (NBITS+3)'(amp_i);
        case (s)
            4'sd1:   contrib_o = a;
            4'sd2:   contrib_o = a <<< 1;
            4'sd4:   contrib_o = a <<< 2;
            -4'sd1:  contrib_o = -a;
            -4'sd2:  contrib_o = -(a <<< 1);
            -4'sd4:  contrib_o = -(a <<< 2);
            default: contrib_o = '0;
        endcase
    end
endmodule

module matched_filter_pulse_inject #(
    parameter int NBITS   = 12,
    parameter int NSAMPS  = 8,
    parameter int HOLDOFF = 16
) (
    input  logic                    aclk,
    input  logic                    aclk_rst,
    input  logic [NBITS*NSAMPS-1:0] data_i,
    output logic [NBITS*NSAMPS-1:0] data_o,
    output logic                    sat_o,
    input  logic                    pulse_req_i,
    input  logic [NBITS-1:0]        amp_i,
    input  logic [2:0]              phase_i,
    output logic                    pulse_ack_o,
    output logic                    busy_o
);
    localparam int CW = NBITS + 3;
    localparam int SW = NBITS + 4;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (NBITS-1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      beat_q, beat_d;
    logic [HW-1:0]                   hcnt_q, hcnt_d;
    logic [NBITS-1:0]                amp_q, amp_d;
    logic [2:0]                      ph_q, ph_d;
    logic                            busy_q;
    logic                            ack;

    logic [NSAMPS-1:0][CW-1:0]       contrib;
    logic [NSAMPS-1:0][NBITS-1:0]    d1_q;
    logic [NSAMPS-1:0][CW-1:0]       c1_q;
    logic [NSAMPS-1:0][NBITS-1:0]    lane_out;
    logic [NSAMPS-1:0]               lane_sat;
    logic [NSAMPS-1:0][NBITS-1:0]    dout_q;
    logic                            sat_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hcnt_d  = hcnt_q;
        amp_d   = amp_q;
        ph_d    = ph_q;
        ack     = 1'b0;
        case (state_q)
            IDLE: if (pulse_req_i) begin
                ack     = 1'b1;
                amp_d   = amp_i;
                ph_d    = phase_i;
                beat_d  = '0;
                state_d = PLAY;
            end
            // Phase 7 pushes the 42-sample template across a seventh beat.
            PLAY: if (beat_q == ((ph_q == 3'd7) ? 3'd6 : 3'd5)) begin
                hcnt_d  = '0;
                state_d = HOLD;
            end else begin
                beat_d = beat_q + 3'd1;
            end
            HOLD: if (hcnt_q == HW'(HOLDOFF - 1)) state_d = IDLE;
                  else hcnt_d = hcnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign pulse_ack_o = ack && !aclk_rst;
    assign busy_o      = busy_q;

    for (genvar k = 0; k < NSAMPS; k++) begin : g_lane
        logic signed [7:0]    n;
        logic signed [SW-1:0] sum;

        assign n = $signed({2'b00, beat_q, 3'b000}) + $signed(8'(k)) - $signed({5'b00000, ph_q});

        mfpi_lane #(.NBITS(NBITS)) u_lane (
            .active_i  (state_q == PLAY),
            .n_i       (n),
            .amp_i     ($signed(amp_q)),
            .contrib_o (contrib[k])
        );

        assign sum = SW'($signed(d1_q[k])) + SW'($signed(c1_q[k]));

        always_comb begin
            lane_sat[k] = (sum > SMAX) || (sum < SMIN);
            if (sum > SMAX)      lane_out[k] = SMAX[NBITS-1:0];
            else if (sum < SMIN) lane_out[k] = SMIN[NBITS-1:0];
            else                 lane_out[k] = sum[NBITS-1:0];
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hcnt_q  <= '0;
            amp_q   <= '0;
            ph_q    <= '0;
            busy_q  <= 1'b0;
            d1_q    <= '0;
            c1_q    <= '0;
            dout_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hcnt_q  <= hcnt_d;
            amp_q   <= amp_d;
            ph_q    <= ph_d;
            busy_q  <= (state_d != IDLE);
            d1_q    <= data_i;
            c1_q    <= contrib;
            dout_q  <= lane_out;
            sat_q   <= |lane_sat;
        end
    end

    assign data_o = dout_q;
    assign sat_o  = sat_q;
endmodule
